// File: rtl/pll_seq_pkg.sv
// Shared types, default timing constants and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      HOLD,
      RUN,
      FAIL
   } pll_seq_state_e;

   localparam int unsigned DEF_SYNC_STAGES      = 2;
   localparam int unsigned DEF_PLL_RST_CYC      = 16;
   localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
   localparam int unsigned DEF_RST_HOLD_CYC     = 256;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 500000;
   localparam int unsigned DEF_MAX_RETRY        = 7;

   // Bits needed to hold any value 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage flop synchronizer for a single asynchronous level; output is the last stage.
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock, and releases the core system reset only after
// a stable lock; retries on lock timeout and re-sequences on lock loss.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES,
   parameter int unsigned PLL_RST_CYC      = DEF_PLL_RST_CYC,
   parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
   parameter int unsigned RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
   parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
   parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
   input  logic       refclk_i,
   input  logic       rst_n_i,
   input  logic       pll_locked_i,
   input  logic       force_relock_i,
   output logic       pll_rst_o,
   output logic       sys_rst_o,
   output logic       ready_o,
   output logic       fail_o,
   output logic [3:0] retry_cnt_o
);

   localparam int unsigned CNT_W = cnt_width(max3(PLL_RST_CYC, LOCK_STABLE_CYC, RST_HOLD_CYC));
   localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT_CYC);

   localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
   // HOLD counts its entry cycle plus RST_HOLD_CYC further cycles of sys_rst.
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYC);
   localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

   pll_seq_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [TMO_W-1:0] tmo_q;
   logic [3:0]       retry_q, retry_d;
   logic             pll_rst_q, sys_rst_q, ready_q, fail_q;
   logic             locked_s;
   logic             lock_tmo;

   sync_bit #(
      .STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk_i  (refclk_i),
      .rst_n_i(rst_n_i),
      .d_i    (pll_locked_i),
      .q_o    (locked_s)
   );

   assign lock_tmo = (tmo_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      unique case (state_q)
         PLL_RST: begin
            if (cnt_q == PRST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK, STABLE: begin
            if (lock_tmo) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = FAIL;
               end else begin
                  retry_d = retry_q + 4'd1;
                  state_d = PLL_RST;
               end
            end else if (state_q == WAIT_LOCK) begin
               if (locked_s) state_d = STABLE;
            end else if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = HOLD;
            end
         end
         HOLD, RUN: begin
            // A lock drop after qualification starts a fresh sequence with a full retry budget.
            if (!locked_s) begin
               state_d = PLL_RST;
               retry_d = '0;
            end else if (state_q == HOLD && cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = PLL_RST;
            retry_d = '0;
         end
      endcase
      if (force_relock_i && state_q != PLL_RST) begin
         state_d = PLL_RST;
         retry_d = '0;
      end
   end

   always_ff @(posedge refclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= PLL_RST;
         cnt_q     <= '0;
         tmo_q     <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;

         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (state_q == PLL_RST || state_q == STABLE || state_q == HOLD) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         // tmo survives STABLE->WAIT_LOCK bounces so lock glitches cannot stretch the budget.
         if (state_q == PLL_RST) begin
            tmo_q <= '0;
         end else if (state_q == WAIT_LOCK || state_q == STABLE) begin
            tmo_q <= tmo_q + TMO_W'(1);
         end

         pll_rst_q <= (state_d == PLL_RST);
         sys_rst_q <= (state_d != RUN);
         ready_q   <= (state_d == RUN);
         fail_q    <= (state_d == FAIL);
      end
   end

   assign pll_rst_o   = pll_rst_q;
   assign sys_rst_o   = sys_rst_q;
   assign ready_o     = ready_q;
   assign fail_o      = fail_q;
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: timestamp-based reference model compared every cycle, plus
// hand-computed event edges for the directed scenarios and randomized lock/relock traffic.
module tb_pll_reset_sequencer;

   localparam int SYNC_STAGES      = 2;
   localparam int PLL_RST_CYC      = 4;
   localparam int LOCK_STABLE_CYC  = 8;
   localparam int RST_HOLD_CYC     = 6;
   localparam int LOCK_TIMEOUT_CYC = 50;
   localparam int MAX_RETRY        = 2;

   logic       refclk;
   logic       rst_n;
   logic       pll_locked;
   logic       force_relock;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [3:0] retry_cnt;

   int checks = 0;
   int errors = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .PLL_RST_CYC     (PLL_RST_CYC),
      .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
      .RST_HOLD_CYC    (RST_HOLD_CYC),
      .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
      .MAX_RETRY       (MAX_RETRY)
   ) dut (
      .refclk_i      (refclk),
      .rst_n_i       (rst_n),
      .pll_locked_i  (pll_locked),
      .force_relock_i(force_relock),
      .pll_rst_o     (pll_rst),
      .sys_rst_o     (sys_rst),
      .ready_o       (ready),
      .fail_o        (fail),
      .retry_cnt_o   (retry_cnt)
   );

   initial refclk = 1'b0;
   always #10 refclk = ~refclk;

   // ---------------- reference model (edge timestamps) ----------------
   // cyc: index of the last refclk edge since reset release (-1 while in reset).
   // m_a: first edge after the current PLL reset attempt began.
   // m_run: edge where the synchronized lock was first seen in the current unbroken run.
   // m_q: edge where lock qualified as stable (-1 if not qualified).
   int cyc;
   int m_a, m_r, m_q, m_run;
   bit m_failed;
   bit samp[$];

   task automatic model_clear();
      cyc = -1; m_a = 0; m_r = 0; m_q = -1; m_run = -1; m_failed = 1'b0;
      samp.delete();
   endtask

   task automatic model_restart(input bit clr_retry);
      m_a = cyc + 1; m_q = -1; m_run = -1; m_failed = 1'b0;
      if (clr_retry) m_r = 0;
   endtask

   task automatic model_step(input bit x, input bit frc);
      if (m_failed) begin
         if (frc) model_restart(1'b1);
      end else if (cyc <= m_a + PLL_RST_CYC - 1) begin
         // still inside the PLL reset pulse: lock and relock requests are ignored
      end else if (m_q >= 0) begin
         if (frc || !x) model_restart(1'b1);
      end else if (frc) begin
         model_restart(1'b1);
      end else if (cyc == m_a + PLL_RST_CYC - 1 + LOCK_TIMEOUT_CYC) begin
         if (m_r == MAX_RETRY) m_failed = 1'b1;
         else begin
            m_r++;
            model_restart(1'b0);
         end
      end else if (x) begin
         if (m_run < 0) m_run = cyc;
         if (cyc - m_run == LOCK_STABLE_CYC) m_q = cyc;
      end else begin
         m_run = -1;
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge refclk or negedge rst_n);
         if (!rst_n) begin
            model_clear();
         end else begin
            cyc++;
            samp.push_back(pll_locked);
            model_step((cyc >= SYNC_STAGES) ? samp[cyc - SYNC_STAGES] : 1'b0, force_relock);
         end
      end
   end

   function automatic logic [7:0] model_outputs();
      logic e_pll_rst, e_ready;
      e_pll_rst = !m_failed && (cyc <= m_a + PLL_RST_CYC - 2);
      e_ready   = !m_failed && (m_q >= 0) && (cyc >= m_q + RST_HOLD_CYC + 1);
      return {e_pll_rst, !e_ready, e_ready, m_failed, 4'(m_r)};
   endfunction

   task automatic check_vec(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got {pll_rst,sys_rst,ready,fail,retry}=%b want=%b",
                  nm, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   // ---------------- per-cycle compare + event capture ----------------
   int  ev_pll_rst_rise, ev_pll_rst_fall, n_pll_rst_rise;
   int  ev_sys_rst_rise, ev_sys_rst_fall, ev_ready_rise, ev_fail_rise, ev_fail_fall;
   logic p_pll_rst, p_sys_rst, p_ready, p_fail;

   initial begin
      forever begin
         @(negedge refclk);
         check_vec("cycle", {pll_rst, sys_rst, ready, fail, retry_cnt}, model_outputs());
         if (!rst_n) begin
            ev_pll_rst_rise = -1; ev_pll_rst_fall = -1; n_pll_rst_rise = 0;
            ev_sys_rst_rise = -1; ev_sys_rst_fall = -1; ev_ready_rise = -1;
            ev_fail_rise = -1; ev_fail_fall = -1;
            p_pll_rst = 1'b1; p_sys_rst = 1'b1; p_ready = 1'b0; p_fail = 1'b0;
         end else begin
            if (pll_rst && !p_pll_rst) begin ev_pll_rst_rise = cyc; n_pll_rst_rise++; end
            if (!pll_rst && p_pll_rst) ev_pll_rst_fall = cyc;
            if (sys_rst && !p_sys_rst) ev_sys_rst_rise = cyc;
            if (!sys_rst && p_sys_rst) ev_sys_rst_fall = cyc;
            if (ready && !p_ready) ev_ready_rise = cyc;
            if (fail && !p_fail) ev_fail_rise = cyc;
            if (!fail && p_fail) ev_fail_fall = cyc;
            p_pll_rst = pll_rst; p_sys_rst = sys_rst; p_ready = ready; p_fail = fail;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic apply_reset();
      @(negedge refclk);
      rst_n = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;
      repeat (3) @(negedge refclk);
      rst_n = 1'b1;
   endtask

   // Returns at the falling edge where the last completed rising edge index equals c.
   task automatic wait_until(input int c);
      while (cyc < c) @(negedge refclk);
   endtask

   int f_edge;

   initial begin
      rst_n = 1'b1; pll_locked = 1'b0; force_relock = 1'b0;
      #5 rst_n = 1'b0;

      // 1 + 4: nominal bring-up, then lock loss in RUN and relock
      apply_reset();
      wait_until(19); pll_locked = 1'b1;
      wait_until(45);
      check_int("nominal_pll_rst_fall", ev_pll_rst_fall, 3);
      check_int("nominal_ready_rise", ev_ready_rise, 37);
      check_int("nominal_sys_rst_fall", ev_sys_rst_fall, 37);
      $display("scenario nominal: ready at edge %0d, retry=%0d", ev_ready_rise, retry_cnt);
      pll_locked = 1'b0;
      wait_until(59); pll_locked = 1'b1;
      wait_until(85);
      check_int("loss_sys_rst_rise", ev_sys_rst_rise, 48);
      check_int("loss_pll_rst_rise", ev_pll_rst_rise, 48);
      check_int("loss_pll_rst_pulses", n_pll_rst_rise, 1);
      check_int("loss_relock_ready_rise", ev_ready_rise, 77);
      $display("scenario loss_in_run: sys_rst at %0d, ready again at %0d", ev_sys_rst_rise, ev_ready_rise);

      // 2: one-cycle lock glitch while qualifying
      apply_reset();
      wait_until(19); pll_locked = 1'b1;
      wait_until(24); pll_locked = 1'b0;
      wait_until(25); pll_locked = 1'b1;
      wait_until(50);
      check_int("glitch_ready_rise", ev_ready_rise, 43);
      check_int("glitch_no_pll_rst", n_pll_rst_rise, 0);
      $display("scenario glitch: ready at edge %0d", ev_ready_rise);

      // 3: never locks -> retries then FAIL, held 500 cycles
      apply_reset();
      wait_until(161 + 500);
      check_int("timeout_pll_rst_pulses", n_pll_rst_rise, 2);
      check_int("timeout_last_pll_rst_rise", ev_pll_rst_rise, 107);
      check_int("timeout_fail_rise", ev_fail_rise, 161);
      $display("scenario timeout: fail at edge %0d after %0d retries", ev_fail_rise, retry_cnt);

      // 5: recovery from FAIL via force_relock
      force_relock = 1'b1; pll_locked = 1'b1; f_edge = cyc + 1;
      @(negedge refclk); force_relock = 1'b0;
      wait_until(f_edge + 30);
      check_int("recover_fail_fall", ev_fail_fall, f_edge);
      check_int("recover_pll_rst_rise", ev_pll_rst_rise, f_edge);
      check_int("recover_ready_rise", ev_ready_rise, f_edge + 20);
      $display("scenario recovery: force at %0d, ready at %0d", f_edge, ev_ready_rise);

      // 6: asynchronous reset mid-HOLD, checked before any further clock edge
      apply_reset();
      wait_until(19); pll_locked = 1'b1;
      wait_until(33);
      #3 rst_n = 1'b0;
      #1 check_vec("async_reset", {pll_rst, sys_rst, ready, fail, retry_cnt}, 8'b1100_0000);
      $display("scenario async_reset: outputs %b%b%b%b retry=%0d", pll_rst, sys_rst, ready, fail, retry_cnt);
      @(negedge refclk);

      // randomized lock behaviour and relock requests
      for (int ep = 0; ep < 6; ep++) begin
         int  hold;
         bit  lvl;
         hold = 0; lvl = 1'b0;
         apply_reset();
         for (int i = 0; i < 400; i++) begin
            @(negedge refclk);
            if (hold == 0) begin
               lvl  = ($urandom_range(0, 3) >= (ep % 3));
               hold = lvl ? $urandom_range(5, 80) : $urandom_range(1, 30);
            end
            pll_locked   = lvl;
            hold--;
            force_relock = ($urandom_range(0, 149) == 0);
         end
         force_relock = 1'b0;
         $display("random episode %0d: end cyc=%0d retry=%0d ready=%0d fail=%0d",
                  ep, cyc, retry_cnt, ready, fail);
      end

      @(negedge refclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
